// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-memory path: load/store formats,
// arbiter FSM states, read-owner tags and default arbitration limits.
package dmem_arbiter_pkg;

    localparam int DATA_SIZE      = 32;
    localparam int DMEM_ADDR_W    = 9;
    localparam int STARVE_MAX_DEF = 4;
    localparam int BURST_MAX_DEF  = 8;

    typedef enum logic [2:0] {
        lb_conf  = 3'd0,
        lh_conf  = 3'd1,
        lw_conf  = 3'd2,
        lbu_conf = 3'd3,
        lhu_conf = 3'd4
    } load_conf;

    typedef enum logic [1:0] {
        sb_conf = 2'd0,
        sh_conf = 2'd1,
        sw_conf = 2'd2
    } store_conf;

    typedef enum logic {
        CORE_PRI  = 1'b0,
        DMA_BURST = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DMA  = 2'd2
    } arb_owner_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the core load/store unit and a DMA
// requester. Core has priority, a starvation counter forces the DMA through
// after STARVE_MAX lost cycles, and a locked DMA burst may hold the port for
// up to BURST_MAX consecutive grants. Granted reads are tagged so the word
// returned one cycle later reaches only its owner.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int BURST_MAX  = BURST_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    // core load/store unit
    input  logic                   core_re,
    input  logic                   core_we,
    input  logic [DMEM_ADDR_W-1:0] core_addr,
    input  logic [DATA_SIZE-1:0]   core_wdata,
    input  load_conf               core_load_type,
    input  store_conf              core_store_type,
    output logic                   core_stall,
    output logic [DATA_SIZE-1:0]   core_rdata,
    output logic                   core_rvalid,
    // DMA / loader
    input  logic                   dma_req,
    input  logic                   dma_we,
    input  logic                   dma_lock,
    input  logic [DMEM_ADDR_W-1:0] dma_addr,
    input  logic [DATA_SIZE-1:0]   dma_wdata,
    output logic                   dma_gnt,
    output logic [DATA_SIZE-1:0]   dma_rdata,
    output logic                   dma_rvalid,
    // data-memory controller
    output logic                   mem_re,
    output logic                   mem_we,
    output logic [DMEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_SIZE-1:0]   mem_wdata,
    output load_conf               mem_load_type,
    output store_conf              mem_store_type,
    input  logic [DATA_SIZE-1:0]   mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_MAX);
    localparam logic [BW-1:0] C_BURST_LAST = BW'(BURST_MAX - 1);
    // A one-grant burst limit never needs the burst state at all.
    localparam bit C_BURST_EN = (BURST_MAX > 1);

    arb_state_t    r_state;
    logic [SW-1:0] r_starve_cnt;
    logic [BW-1:0] r_burst_cnt;
    arb_owner_t    r_rd_owner;

    logic w_core_act;
    logic w_burst_go;
    logic w_starved;
    logic w_core_gnt;
    logic w_dma_gnt;

    // Per-cycle grant decision and memory-port mux; burst continuation
    // overrides core priority, otherwise core wins unless the DMA is starved.
    always_comb begin
        w_core_act     = core_re | core_we;
        w_burst_go     = (r_state == DMA_BURST) & dma_req & dma_lock;
        w_starved      = (r_starve_cnt == C_STARVE_MAX);
        w_dma_gnt      = 1'b0;
        w_core_gnt     = 1'b0;
        mem_re         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_load_type  = lw_conf;
        mem_store_type = sw_conf;

        if (w_burst_go) begin
            w_dma_gnt = 1'b1;
        end else begin
            w_dma_gnt  = dma_req & (~w_core_act | w_starved);
            w_core_gnt = w_core_act & ~w_dma_gnt;
        end

        if (w_core_gnt) begin
            mem_re         = core_re;
            mem_we         = core_we;
            mem_addr       = core_addr;
            mem_wdata      = core_wdata;
            mem_load_type  = core_load_type;
            mem_store_type = core_store_type;
        end else if (w_dma_gnt) begin
            mem_re    = ~dma_we;
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign core_stall = w_core_act & ~w_core_gnt;
    assign dma_gnt    = w_dma_gnt;

    // Read return: the tagged owner sees the controller word for one cycle,
    // the other requester sees zero.
    assign core_rvalid = (r_rd_owner == OWN_CORE);
    assign dma_rvalid  = (r_rd_owner == OWN_DMA);
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign dma_rdata   = dma_rvalid  ? mem_rdata : '0;

    // FSM, starvation/burst counters and read-owner tag; reset drops any
    // read still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= CORE_PRI;
            r_starve_cnt <= '0;
            r_burst_cnt  <= '0;
            r_rd_owner   <= OWN_NONE;
        end else begin
            if (w_core_gnt & core_re)
                r_rd_owner <= OWN_CORE;
            else if (w_dma_gnt & ~dma_we)
                r_rd_owner <= OWN_DMA;
            else
                r_rd_owner <= OWN_NONE;

            if (w_burst_go) begin
                r_burst_cnt  <= r_burst_cnt + 1'b1;
                r_starve_cnt <= '0;
                if (r_burst_cnt == C_BURST_LAST)
                    r_state <= CORE_PRI;
            end else begin
                if (C_BURST_EN && w_dma_gnt && dma_lock) begin
                    r_state     <= DMA_BURST;
                    r_burst_cnt <= BW'(1);
                end else begin
                    r_state     <= CORE_PRI;
                    r_burst_cnt <= '0;
                end
                // Core win only counts as starvation while the DMA is waiting;
                // at the limit the DMA wins, so the counter cannot pass it.
                if (~dma_req | w_dma_gnt)
                    r_starve_cnt <= '0;
                else if (w_core_gnt)
                    r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a small controller stand-in, a cycle model of the
// arbitration rules and a read-return scoreboard.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_re, core_we;
    logic [8:0]  core_addr;
    logic [31:0] core_wdata;
    load_conf    core_load_type;
    store_conf   core_store_type;
    logic        core_stall;
    logic [31:0] core_rdata;
    logic        core_rvalid;
    logic        dma_req, dma_we, dma_lock;
    logic [8:0]  dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic        dma_rvalid;
    logic        mem_re, mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    load_conf    mem_load_type;
    store_conf   mem_store_type;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_MAX(4), .BURST_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .core_re(core_re), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_load_type(core_load_type),
        .core_store_type(core_store_type), .core_stall(core_stall),
        .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
        .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_load_type(mem_load_type),
        .mem_store_type(mem_store_type), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] fmt(input logic [31:0] w, input load_conf lt);
        case (lt)
            lb_conf:  fmt = {{24{w[7]}}, w[7:0]};
            lbu_conf: fmt = {24'h0, w[7:0]};
            default:  fmt = w;
        endcase
    endfunction

    // Controller stand-in: byte or word store, formatted read one cycle later.
    logic [31:0] fmem [512];
    logic [31:0] r_ctrl_rdata;
    logic        tb_clr;
    assign mem_rdata = r_ctrl_rdata;
    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 512; i++) fmem[i] <= '0;
            r_ctrl_rdata <= '0;
        end else begin
            if (mem_we) begin
                if (mem_store_type == sb_conf) fmem[mem_addr][7:0] <= mem_wdata[7:0];
                else fmem[mem_addr] <= mem_wdata;
            end
            r_ctrl_rdata <= mem_re ? fmt(fmem[mem_addr], mem_load_type) : 32'h0;
        end
    end

    typedef struct {
        int          owner;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    logic [31:0] shadow [512];
    int n_cmp = 0;
    int n_mis = 0;

    int m_state, m_starve, m_burst, n_state, n_starve, n_burst;
    bit pw_en, pw_byte;
    logic [8:0]  pw_addr;
    logic [31:0] pw_data;
    bit g_core, g_dma;
    logic obs_core_stall, obs_dma_gnt;
    logic [8:0] obs_mem_addr;
    store_conf obs_store_type;
    logic [31:0] last_core_rdata, last_dma_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        core_re = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        core_load_type = lw_conf; core_store_type = sw_conf;
        dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = '0; dma_wdata = '0;
    endtask

    task automatic model_reset();
        m_state = 0; m_starve = 0; m_burst = 0;
        pw_en = 0;
        q.delete();
    endtask

    // Evaluate the request cycle: expected grant, memory drive and read tag.
    task automatic issue();
        bit act, burst_go, eg_core, eg_dma;
        logic er, ew;
        logic [8:0] ea;
        logic [31:0] ed;
        load_conf elt;
        store_conf est;
        exp_t e;
        #2;
        act      = core_re | core_we;
        burst_go = (m_state == 1) && dma_req && dma_lock;
        if (burst_go) begin
            eg_dma = 1; eg_core = 0;
        end else begin
            eg_dma  = dma_req && (!act || m_starve == 4);
            eg_core = act && !eg_dma;
        end
        er = 0; ew = 0; ea = '0; ed = '0; elt = lw_conf; est = sw_conf;
        if (eg_core) begin
            er = core_re; ew = core_we; ea = core_addr; ed = core_wdata;
            elt = core_load_type; est = core_store_type;
        end else if (eg_dma) begin
            er = !dma_we; ew = dma_we; ea = dma_addr; ed = dma_wdata;
        end
        check("core_stall", core_stall, act && !eg_core);
        check("dma_gnt", dma_gnt, eg_dma);
        check("mem_re", mem_re, er);
        check("mem_we", mem_we, ew);
        check("mem_addr", mem_addr, ea);
        check("mem_wdata", mem_wdata, ed);
        check("mem_load_type", 32'(mem_load_type), 32'(elt));
        check("mem_store_type", 32'(mem_store_type), 32'(est));
        obs_core_stall = core_stall; obs_dma_gnt = dma_gnt;
        obs_mem_addr = mem_addr; obs_store_type = mem_store_type;
        g_core = eg_core; g_dma = eg_dma;
        if (er) begin
            e.owner = eg_core ? 1 : 2;
            e.data  = fmt(shadow[ea], elt);
            q.push_back(e);
        end
        pw_en = ew; pw_addr = ea; pw_data = ed; pw_byte = (est == sb_conf);
        if (burst_go) begin
            n_burst = m_burst + 1; n_starve = 0; n_state = (m_burst == 7) ? 0 : 1;
        end else begin
            n_state  = (eg_dma && dma_lock) ? 1 : 0;
            n_burst  = n_state;
            n_starve = (!dma_req || eg_dma) ? 0 : (eg_core ? m_starve + 1 : m_starve);
        end
    endtask

    // Close the cycle and check the read return of the cycle just ended.
    task automatic resp();
        exp_t e;
        logic ecv, edv;
        logic [31:0] ecd, edd;
        @(posedge clk); #1;
        if (pw_en) begin
            if (pw_byte) shadow[pw_addr][7:0] = pw_data[7:0];
            else shadow[pw_addr] = pw_data;
        end
        pw_en = 0;
        m_state = n_state; m_starve = n_starve; m_burst = n_burst;
        ecv = 0; edv = 0; ecd = '0; edd = '0;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.owner == 1) begin ecv = 1; ecd = e.data; end
            else begin edv = 1; edd = e.data; end
        end
        check("core_rvalid", core_rvalid, ecv);
        check("dma_rvalid", dma_rvalid, edv);
        check("core_rdata", core_rdata, ecd);
        check("dma_rdata", dma_rdata, edd);
        if (core_rvalid) last_core_rdata = core_rdata;
        if (dma_rvalid) last_dma_rdata = dma_rdata;
    endtask

    task automatic cyc();
        issue();
        resp();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_core_stall"}, core_stall, 0);
        check({pfx, "_dma_gnt"}, dma_gnt, 0);
        check({pfx, "_mem_re"}, mem_re, 0);
        check({pfx, "_mem_we"}, mem_we, 0);
        check({pfx, "_mem_addr"}, mem_addr, 0);
        check({pfx, "_mem_wdata"}, mem_wdata, 0);
        check({pfx, "_mem_lt"}, 32'(mem_load_type), 32'(lw_conf));
        check({pfx, "_mem_st"}, 32'(mem_store_type), 32'(sw_conf));
        check({pfx, "_core_rvalid"}, core_rvalid, 0);
        check({pfx, "_dma_rvalid"}, dma_rvalid, 0);
        check({pfx, "_core_rdata"}, core_rdata, 0);
        check({pfx, "_dma_rdata"}, dma_rdata, 0);
    endtask

    initial begin
        int dgc, run, max_run, stalls, ngnt;
        bit core_done, dma_done;
        logic [8:0] a;
        for (int i = 0; i < 512; i++) shadow[i] = '0;
        model_reset();
        last_core_rdata = '0; last_dma_rdata = '0;
        set_idle();
        rst = 1; tb_clr = 1;
        @(posedge clk); #1;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        tb_clr = 0; rst = 0;

        // Preload two words through DMA writes with the core idle.
        dma_req = 1; dma_we = 1; dma_addr = 9'h010; dma_wdata = 32'h12345678;
        cyc();
        dma_addr = 9'h1FF; dma_wdata = 32'hCAFEF00D;
        cyc();
        set_idle();

        // Core read with no DMA traffic.
        core_re = 1; core_addr = 9'h010;
        cyc();
        check("t1_stall", obs_core_stall, 0);
        set_idle();
        cyc();
        check("t1_rdata", last_core_rdata, 32'h12345678);

        // Continuous core reads starve the DMA until it is forced through.
        dgc = -1; a = 9'h000;
        core_re = 1; core_addr = a;
        dma_req = 1; dma_we = 0; dma_addr = 9'h1FF;
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (g_dma) begin dgc = c; dma_req = 0; end
            if (g_core) begin a = a + 9'd1; core_addr = a; end
        end
        check("t2_dma_cycle", dgc, 4);
        check("t2_dma_rdata", last_dma_rdata, 32'hCAFEF00D);
        set_idle();
        cyc();

        // DMA full-word write racing a core byte store to the same word.
        core_we = 1; core_store_type = sb_conf; core_addr = 9'h0A5; core_wdata = 32'h11;
        dma_req = 1; dma_we = 1; dma_addr = 9'h0A5; dma_wdata = 32'hDEADBEEF;
        core_done = 0; dma_done = 0;
        for (int c = 0; c < 4 && !(core_done && dma_done); c++) begin
            cyc();
            if (g_core) begin core_done = 1; core_we = 0; end
            if (g_dma) begin
                dma_done = 1; dma_req = 0;
                check("t3_dma_sw", 32'(obs_store_type), 32'(sw_conf));
            end
        end
        set_idle();
        core_re = 1; core_addr = 9'h0A5; core_load_type = lw_conf;
        cyc();
        set_idle();
        cyc();
        check("t3_lw_a5", last_core_rdata, 32'hDEADBEEF);

        // Locked DMA burst against an always-active core.
        core_re = 1; core_addr = 9'h010;
        dma_req = 1; dma_lock = 1; dma_we = 0; dma_addr = 9'h1FF;
        run = 0; max_run = 0; stalls = 0;
        for (int c = 0; c < 16; c++) begin
            if (c == 12) begin dma_req = 0; dma_lock = 0; end
            cyc();
            if (obs_dma_gnt) run++; else run = 0;
            if (run > max_run) max_run = run;
            if (obs_core_stall) stalls++;
        end
        check("t4_burst_len", max_run, 8);
        check("t4_stall_cycles", stalls, 8);
        set_idle();
        cyc();

        // Lock released early: the waiting core is served in that cycle.
        dma_req = 1; dma_lock = 1; dma_we = 0; dma_addr = 9'h1FF;
        ngnt = 0;
        cyc();
        if (obs_dma_gnt) ngnt++;
        core_re = 1; core_addr = 9'h010;
        for (int c = 0; c < 2; c++) begin
            cyc();
            if (obs_dma_gnt) ngnt++;
        end
        check("t5_burst_grants", ngnt, 3);
        dma_lock = 0;
        cyc();
        check("t5_core_stall", obs_core_stall, 0);
        check("t5_dma_gnt", obs_dma_gnt, 0);
        check("t5_mem_addr", obs_mem_addr, 9'h010);
        set_idle();
        cyc();

        // Reset pulsed while a DMA read is in flight.
        dma_req = 1; dma_we = 0; dma_addr = 9'h1FF;
        issue();
        set_idle();
        @(posedge clk); #1;
        rst = 1; #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        rst = 0;
        model_reset();
        @(posedge clk); #1;
        check("rst_after_dma_rvalid", dma_rvalid, 0);
        core_re = 1; core_addr = 9'h010;
        cyc();
        set_idle();
        cyc();
        check("rst_recover_rdata", last_core_rdata, 32'h12345678);

        check("sb_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
